// File: rtl/d_search.sv
// d_search: sequential sweep for the modular inverse d of e modulo L, using add/subtract only.
// Optional D_STREAM_EN exposes every swept candidate on d_possible/d_cand_vld.
module d_search #(
    parameter int size = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [size-1:0]   e,
    input  logic [2*size-1:0] L,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [2*size-1:0] d_out,
    output logic [2*size-1:0] d_possible,
    output logic              d_cand_vld
);
    localparam int W = 2 * size;
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] TWO = W'(2);

    // Handshake: start is sampled only in IDLE/DONE; done is a one-cycle pulse,
    // found/d_out are valid with done and held until the next accepted start.
    typedef enum logic [1:0] {IDLE, REDUCE, SEARCH, DONE} state_t;

    state_t          state;
    logic [size-1:0] e_r;
    logic [W-1:0]    l_r;
    logic [W-1:0]    d;
    logic [W-1:0]    r;
    logic [W-1:0]    e_ext;
    logic [W:0]      sum;
    logic [W:0]      diff;

    assign e_ext = {{(W-size){1'b0}}, e_r};
    // One extra bit so r + e_r can never overflow before the modular correction.
    assign sum   = {1'b0, r} + {1'b0, e_ext};
    assign diff  = sum - {1'b0, l_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            e_r   <= '0;
            l_r   <= '0;
            d     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            found <= 1'b0;
            d_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        e_r   <= e;
                        l_r   <= L;
                        busy  <= 1'b1;
                        found <= 1'b0;
                        d_out <= '0;
                        state <= REDUCE;
                    end else begin
                        state <= IDLE;
                    end
                end
                REDUCE: begin
                    if (l_r < TWO) begin
                        found <= 1'b0;
                        d_out <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (e_ext >= l_r) begin
                        // l_r <= e_r here, so its upper half is zero.
                        e_r <= e_r - l_r[size-1:0];
                    end else begin
                        d     <= ONE;
                        r     <= e_ext;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (r == ONE) begin
                        found <= 1'b1;
                        d_out <= d;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (d == l_r - ONE) begin
                        found <= 1'b0;
                        d_out <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        d <= d + ONE;
                        r <= (sum >= {1'b0, l_r}) ? diff[W-1:0] : sum[W-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef D_STREAM_EN
    assign d_cand_vld = (state == SEARCH);
    assign d_possible = (state == SEARCH) ? d : '0;
`else
    assign d_cand_vld = 1'b0;
    assign d_possible = '0;
`endif

endmodule

// File: tb/tb_d_search.sv
// Bench for d_search (size=4): directed vector table, corner sequences, and random
// searches checked against a brute-force modular-inverse model.
module tb_d_search;
    localparam int size = 4;
    localparam int W = 2 * size;
    localparam int LIMIT = 600;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [size-1:0]   e;
    logic [W-1:0]      L;
    logic              busy;
    logic              done;
    logic              found;
    logic [W-1:0]      d_out;
    logic [W-1:0]      d_possible;
    logic              d_cand_vld;

    int n_chk  = 0;
    int n_fail = 0;

    d_search #(.size(size)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .e(e), .L(L),
        .busy(busy), .done(done), .found(found), .d_out(d_out),
        .d_possible(d_possible), .d_cand_vld(d_cand_vld)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    e;
        int    l;
        int    found;
        int    d;
        int    lat;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: smallest d in 1..L-1 with d*e mod L == 1; latency counts one
    // cycle per subtraction that brings e below L, one per candidate, plus two.
    function automatic void model(input int ev, input int lv,
                                  output int f, output int dd, output int lat);
        int k;
        f = 0;
        dd = 0;
        if (lv < 2) begin
            lat = 2;
            return;
        end
        for (int i = 1; i < lv; i++) begin
            if ((i * ev) % lv == 1) begin
                f = 1;
                dd = i;
                break;
            end
        end
        k = f ? dd : lv - 1;
        lat = 2 + ev / lv + k;
    endfunction

    // Called at a negedge; start is presented immediately. Returns in the done cycle.
    task automatic run_search(input int te, input int tl, input int xf, input int xd,
                              input int xlat, input int poke, input string nm);
        int cyc = 0;
        int nv = 0;
        int k;
        bit busy_ok = 1'b1;
        bit seq_ok = 1'b1;
        e = te[size-1:0];
        L = tl[W-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < LIMIT) begin
            if (!busy) busy_ok = 1'b0;
            if (d_cand_vld) begin
                nv++;
                if (int'(d_possible) != nv) seq_ok = 1'b0;
            end else if (d_possible != '0) begin
                seq_ok = 1'b0;
            end
            if (cyc == poke) begin
                start = 1'b1;
                e = 4'd3;
                L = 8'd20;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        k = (tl < 2) ? 0 : (xf != 0 ? xd : tl - 1);
        chk({nm, " done"}, int'(done), 1);
        chk({nm, " latency"}, cyc, xlat);
        chk({nm, " found"}, int'(found), xf);
        chk({nm, " d_out"}, int'(d_out), xd);
        chk({nm, " busy_at_done"}, int'(busy), 0);
        chk({nm, " busy_while_running"}, int'(busy_ok), 1);
        chk({nm, " stream_seq"}, int'(seq_ok), 1);
`ifdef D_STREAM_EN
        chk({nm, " stream_count"}, nv, k);
`else
        chk({nm, " stream_count"}, nv, 0);
`endif
    endtask

    initial begin
        int f, dd, lat, ev, lv;
        start = 1'b0;
        e = '0;
        L = '0;
        rst_n = 1'b0;

        vecs.push_back('{7, 40, 1, 23, 25, "e7_L40"});
        vecs.push_back('{3, 20, 1, 7, 9, "e3_L20"});
        vecs.push_back('{4, 20, 0, 0, 21, "e4_L20"});
        vecs.push_back('{13, 12, 1, 1, 4, "e13_L12"});
        vecs.push_back('{5, 1, 0, 0, 2, "L1"});
        vecs.push_back('{5, 0, 0, 0, 2, "L0"});
        vecs.push_back('{15, 2, 1, 1, 10, "e15_L2"});
        vecs.push_back('{0, 16, 0, 0, 17, "e0_L16"});
        vecs.push_back('{5, 8, 1, 5, 7, "e5_L8"});

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset found", int'(found), 0);
        chk("reset d_out", int'(d_out), 0);
        chk("reset d_possible", int'(d_possible), 0);
        chk("reset d_cand_vld", int'(d_cand_vld), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            run_search(vecs[i].e, vecs[i].l, vecs[i].found, vecs[i].d,
                       vecs[i].lat, 0, vecs[i].name);
        end

        // result held after done, done pulse is one cycle
        repeat (3) @(negedge clk);
        chk("hold done_low", int'(done), 0);
        chk("hold found", int'(found), 1);
        chk("hold d_out", int'(d_out), 5);

        // start while busy is ignored
        @(negedge clk);
        run_search(7, 40, 1, 23, 25, 5, "busy_restart");
        // start in the done cycle is accepted back-to-back
        run_search(5, 8, 1, 5, 7, 0, "back_to_back");

        // async reset mid-search at d=10
        @(negedge clk);
        e = 4'd7;
        L = 8'd40;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid busy", int'(busy), 1);
`ifdef D_STREAM_EN
        chk("mid d_possible", int'(d_possible), 10);
`endif
        rst_n = 1'b0;
        #1;
        chk("arst busy", int'(busy), 0);
        chk("arst done", int'(done), 0);
        chk("arst found", int'(found), 0);
        chk("arst d_out", int'(d_out), 0);
        chk("arst d_possible", int'(d_possible), 0);
        chk("arst d_cand_vld", int'(d_cand_vld), 0);
        repeat (3) begin
            @(negedge clk);
            chk("arst no_done", int'(done), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst idle_busy", int'(busy), 0);
        @(negedge clk);
        run_search(7, 40, 1, 23, 25, 0, "after_reset");

        // random searches against the model
        for (int n = 0; n < 40; n++) begin
            ev = int'($urandom_range(0, 15));
            lv = (n % 3 == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
            model(ev, lv, f, dd, lat);
            @(negedge clk);
            run_search(ev, lv, f, dd, lat, 0, $sformatf("rand e%0d_L%0d", ev, lv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
